// File: rtl/square_chan_gen_if.sv
// Register-write, frame-tick and output bundle for one square_chan_gen pulse channel.
// master drives the writes and ticks; slave is the channel itself.
interface square_chan_gen_if;
   logic [7:0] DB;
   logic       WR0;
   logic       WR1;
   logic       WR2;
   logic       WR3;
   logic       WR4;
   logic       nLFO1;
   logic       nLFO2;
   logic       NOSQ;
   logic       LOCK;
   logic       SQ_LC;
   logic [3:0] SQ_Out;

   modport master (
      output DB, WR0, WR1, WR2, WR3, WR4, nLFO1, nLFO2, NOSQ, LOCK,
      input  SQ_LC, SQ_Out
   );

   modport slave (
      input  DB, WR0, WR1, WR2, WR3, WR4, nLFO1, nLFO2, NOSQ, LOCK,
      output SQ_LC, SQ_Out
   );
endinterface

// File: rtl/square_chan_gen.sv
// 2A03-style pulse channel: period timer, duty sequencer, sweep, envelope, gated 4-bit output.
// Define SQGEN_LENGTH_EN to build the length counter; otherwise SQ_LC simply follows !NOSQ.
module square_chan_gen #(
   parameter int unsigned TIMER_W  = 11,
   parameter int unsigned NEG_MODE = 0,
   parameter int unsigned MUTE_MIN = 8
) (
   input  logic             ACLK,
   input  logic             n_RES,
   square_chan_gen_if.slave bus
);

   localparam logic [TIMER_W-1:0] MuteMin = TIMER_W'(MUTE_MIN);
   localparam logic [TIMER_W-1:0] HiMask  = ~TIMER_W'(11'h7FF);
   localparam logic [TIMER_W:0]   SubBias = (TIMER_W+1)'(NEG_MODE == 0);

`ifdef SQGEN_LENGTH_EN
   localparam logic [7:0] LenTab [32] = '{
      8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
      8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
      8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
      8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
   };
   logic [7:0] len_q, len_d;
`endif

   logic [1:0]         duty_q, duty_d;
   logic               loop_q, loop_d, const_q, const_d;
   logic [3:0]         env_v_q, env_v_d;
   logic               sw_en_q, sw_en_d, neg_q, neg_d, reload_q, reload_d;
   logic [2:0]         sper_q, sper_d, sh_q, sh_d, div_q, div_d, step_q, step_d;
   logic [TIMER_W-1:0] per_q, per_d, tmr_q, tmr_d;
   logic               start_q, start_d;
   logic [3:0]         decay_q, decay_d, ediv_q, ediv_d;
   logic               sq_lc_q, sq_lc_d;
   logic [3:0]         sq_out_q, sq_out_d;

   logic [TIMER_W-1:0] shift_w, target_w;
   logic [TIMER_W:0]   add_w, sub_w;
   logic               mute, half, quarter, duty_bit;
   logic [7:0]         duty_pat;

   assign half    = !bus.nLFO2;
   assign quarter = !bus.nLFO1;

   // Sweep target; ones' complement mode subtracts an extra 1, clamped at zero.
   assign shift_w  = per_q >> sh_q;
   assign add_w    = {1'b0, per_q} + {1'b0, shift_w};
   assign sub_w    = {1'b0, per_q} - {1'b0, shift_w} - SubBias;
   assign target_w = !neg_q ? add_w[TIMER_W-1:0] : (sub_w[TIMER_W] ? '0 : sub_w[TIMER_W-1:0]);
   assign mute     = (per_q < MuteMin) | (!neg_q & add_w[TIMER_W]);

   // Patterns stored LSB = step 0.
   always_comb begin
      duty_pat = 8'b0000_0010;
      case (duty_q)
         2'b00:   duty_pat = 8'b0000_0010;
         2'b01:   duty_pat = 8'b0000_0110;
         2'b10:   duty_pat = 8'b0001_1110;
         default: duty_pat = 8'b1111_1001;
      endcase
      duty_bit = duty_pat[step_q];
   end

   always_comb begin
      {duty_d, loop_d, const_d, env_v_d} = {duty_q, loop_q, const_q, env_v_q};
      {sw_en_d, sper_d, neg_d, sh_d}     = {sw_en_q, sper_q, neg_q, sh_q};
      reload_d = reload_q;
      div_d    = div_q;
      per_d    = per_q;
      tmr_d    = tmr_q;
      step_d   = step_q;
      start_d  = start_q;
      decay_d  = decay_q;
      ediv_d   = ediv_q;

      if (bus.WR0) {duty_d, loop_d, const_d, env_v_d} = bus.DB;
      if (bus.WR1) {sw_en_d, sper_d, neg_d, sh_d} = bus.DB;

      if (tmr_q == '0) begin
         tmr_d  = per_q;
         step_d = step_q + 3'd1;
      end else begin
         tmr_d  = tmr_q - 1'b1;
      end
      if (bus.WR3) step_d = '0;

      // The tick sees the pre-write sweep fields; a coinciding WR1 re-arms reload afterwards.
      if (half) begin
         if (div_q == '0 && sw_en_q && sh_q != '0 && !mute) per_d = target_w;
         if (div_q == '0 || reload_q) begin
            div_d    = sper_q;
            reload_d = 1'b0;
         end else begin
            div_d    = div_q - 3'd1;
         end
      end
      if (bus.WR1) reload_d = 1'b1;

      if (bus.WR2 || bus.WR3 || bus.WR4) per_d = per_q;
      if (bus.WR2) per_d[7:0] = bus.DB;
      if (bus.WR3) per_d[10:8] = bus.DB[2:0];
      if (bus.WR4) per_d = (per_d & ~HiMask) | (TIMER_W'({bus.DB, 11'b0}) & HiMask);

      if (quarter) begin
         if (start_q) begin
            start_d = 1'b0;
            decay_d = 4'hF;
            ediv_d  = env_v_q;
         end else if (ediv_q == '0) begin
            ediv_d = env_v_q;
            if (decay_q != '0) decay_d = decay_q - 4'd1;
            else if (loop_q)   decay_d = 4'hF;
         end else begin
            ediv_d = ediv_q - 4'd1;
         end
      end
      if (bus.WR3) start_d = 1'b1;

`ifdef SQGEN_LENGTH_EN
      len_d = len_q;
      if (bus.WR3)                            len_d = LenTab[bus.DB[7:3]];
      else if (half && len_q != '0 && !loop_q) len_d = len_q - 8'd1;
      if (bus.NOSQ) len_d = '0;
      sq_lc_d = (len_q != '0);
`else
      sq_lc_d = !bus.NOSQ;
`endif

      sq_out_d = (duty_bit && !mute && sq_lc_q && !bus.NOSQ && !bus.LOCK)
                 ? (const_q ? env_v_q : decay_q) : 4'd0;
   end

   always_ff @(posedge ACLK or negedge n_RES) begin
      if (!n_RES) begin
         {duty_q, loop_q, const_q, env_v_q} <= '0;
         {sw_en_q, sper_q, neg_q, sh_q}     <= '0;
         reload_q <= 1'b0;
         div_q    <= '0;
         per_q    <= '0;
         tmr_q    <= '0;
         step_q   <= '0;
         start_q  <= 1'b0;
         decay_q  <= '0;
         ediv_q   <= '0;
`ifdef SQGEN_LENGTH_EN
         len_q    <= '0;
`endif
         sq_lc_q  <= 1'b0;
         sq_out_q <= '0;
      end else begin
         {duty_q, loop_q, const_q, env_v_q} <= {duty_d, loop_d, const_d, env_v_d};
         {sw_en_q, sper_q, neg_q, sh_q}     <= {sw_en_d, sper_d, neg_d, sh_d};
         reload_q <= reload_d;
         div_q    <= div_d;
         per_q    <= per_d;
         tmr_q    <= tmr_d;
         step_q   <= step_d;
         start_q  <= start_d;
         decay_q  <= decay_d;
         ediv_q   <= ediv_d;
`ifdef SQGEN_LENGTH_EN
         len_q    <= len_d;
`endif
         sq_lc_q  <= sq_lc_d;
         sq_out_q <= sq_out_d;
      end
   end

   assign bus.SQ_LC  = sq_lc_q;
   assign bus.SQ_Out = sq_out_q;

endmodule

// File: tb/tb_square_chan_gen.sv
// Directed bench for square_chan_gen: u_a uses default generics, u_b uses NEG_MODE=1, MUTE_MIN=2.
// Both instances receive identical stimulus.
module tb_square_chan_gen;
   logic       aclk = 1'b0;
   logic       n_res;
   logic [7:0] db;
   logic       wr0, wr1, wr2, wr3, wr4, nlfo1, nlfo2, nosq, lock;
   logic [7:0] pat;
   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;

   square_chan_gen_if bus_a ();
   square_chan_gen_if bus_b ();

   assign bus_a.DB = db;      assign bus_b.DB = db;
   assign bus_a.WR0 = wr0;    assign bus_b.WR0 = wr0;
   assign bus_a.WR1 = wr1;    assign bus_b.WR1 = wr1;
   assign bus_a.WR2 = wr2;    assign bus_b.WR2 = wr2;
   assign bus_a.WR3 = wr3;    assign bus_b.WR3 = wr3;
   assign bus_a.WR4 = wr4;    assign bus_b.WR4 = wr4;
   assign bus_a.nLFO1 = nlfo1; assign bus_b.nLFO1 = nlfo1;
   assign bus_a.nLFO2 = nlfo2; assign bus_b.nLFO2 = nlfo2;
   assign bus_a.NOSQ = nosq;  assign bus_b.NOSQ = nosq;
   assign bus_a.LOCK = lock;  assign bus_b.LOCK = lock;

   square_chan_gen u_a (.ACLK(aclk), .n_RES(n_res), .bus(bus_a));
   square_chan_gen #(.TIMER_W(11), .NEG_MODE(1), .MUTE_MIN(2)) u_b (
      .ACLK(aclk), .n_RES(n_res), .bus(bus_b)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic write(input int idx, input logic [7:0] d);
      db = d;
      case (idx)
         0:       wr0 = 1'b1;
         1:       wr1 = 1'b1;
         2:       wr2 = 1'b1;
         3:       wr3 = 1'b1;
         default: wr4 = 1'b1;
      endcase
      tick();
      {wr0, wr1, wr2, wr3, wr4} = '0;
   endtask

   task automatic half_tick();
      nlfo2 = 1'b0;
      tick();
      nlfo2 = 1'b1;
   endtask

   task automatic quarter_tick();
      nlfo1 = 1'b0;
      tick();
      nlfo1 = 1'b1;
      tick();
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_res = 1'b0; db = '0; {wr0, wr1, wr2, wr3, wr4} = '0;
      nlfo1 = 1'b1; nlfo2 = 1'b1; nosq = 1'b0; lock = 1'b0;
      #12;
      check("rst_out_a", 16'(bus_a.SQ_Out), 16'd0);
      check("rst_lc_a", 16'(bus_a.SQ_LC), 16'd0);
      check("rst_out_b", 16'(bus_b.SQ_Out), 16'd0);
      check("rst_per_a", 16'(u_a.per_q), 16'h0);
      n_res = 1'b1;
      tick();
`ifdef SQGEN_LENGTH_EN
      check("rst_lc_after", 16'(bus_a.SQ_LC), 16'd0);
`else
      check("rst_lc_after", 16'(bus_a.SQ_LC), 16'd1);
`endif

      // 1: P=3, duty 10, constant volume 15; each step lasts 4 clocks, output lags one clock
      write(0, 8'h9F);
      write(2, 8'h03);
      write(3, 8'h00);
      pat = 8'b0001_1110;
      for (int k = 1; k <= 32; k++) begin
         tick();
         check("t1_duty_b", 16'(bus_b.SQ_Out), pat[(k-1)/4] ? 16'd15 : 16'd0);
         check("t1_mute_a", 16'(bus_a.SQ_Out), 16'd0);
      end

      // 4: mute by MUTE_MIN and by add overflow; negate clears overflow mute
      write(0, 8'hDF);
      write(2, 8'h07);
      write(3, 8'h00);
      tick();
      check("t4_min_a", 16'(bus_a.SQ_Out), 16'd0);
      check("t4_min_b", 16'(bus_b.SQ_Out), 16'd15);
      write(2, 8'hFF);
      write(1, 8'h01);
      write(3, 8'h07);
      tick();
      check("t4_ovf_a", 16'(bus_a.SQ_Out), 16'd0);
      check("t4_ovf_b", 16'(bus_b.SQ_Out), 16'd0);
      write(1, 8'h09);
      write(3, 8'h07);
      tick();
      check("t4_neg_a", 16'(bus_a.SQ_Out), 16'd15);
      check("t4_neg_b", 16'(bus_b.SQ_Out), 16'd15);

      // 2: sweep add, then shift 0 leaves P alone
      write(2, 8'h00);
      write(3, 8'h01);
      write(1, 8'h81);
      half_tick();
      check("t2_add_a", 16'(u_a.per_q), 16'h180);
      check("t2_add_b", 16'(u_b.per_q), 16'h180);
      write(1, 8'h80);
      half_tick();
      check("t2_sh0_a", 16'(u_a.per_q), 16'h180);

      // 3: sweep negate in both modes
      write(2, 8'h00);
      write(3, 8'h01);
      write(1, 8'h89);
      half_tick();
      check("t3_neg1s_a", 16'(u_a.per_q), 16'h07F);
      check("t3_neg2s_b", 16'(u_b.per_q), 16'h080);
      // a period write on the tick cycle suppresses the sweep
      db = 8'h55; wr2 = 1'b1; nlfo2 = 1'b0;
      tick();
      wr2 = 1'b0; nlfo2 = 1'b1;
      check("t3_wrwins_a", 16'(u_a.per_q), 16'h055);
      check("t3_wrwins_b", 16'(u_b.per_q), 16'h055);

      // 5: envelope decay, divider period V+1 quarter ticks
      write(1, 8'h00);
      write(0, 8'h02);
      write(3, 8'h01);
      quarter_tick();
      check("t5_tick1", 16'(u_a.decay_q), 16'd15);
      quarter_tick();
      check("t5_tick2", 16'(u_a.decay_q), 16'd15);
      repeat (2) quarter_tick();
      check("t5_tick4", 16'(u_a.decay_q), 16'd14);
      repeat (3) quarter_tick();
      check("t5_tick7", 16'(u_a.decay_q), 16'd13);
      write(0, 8'h20);
      write(3, 8'h01);
      repeat (16) quarter_tick();
      check("t5_loop_zero", 16'(u_a.decay_q), 16'd0);
      quarter_tick();
      check("t5_loop_wrap", 16'(u_a.decay_q), 16'd15);

      // 6: length counter / NOSQ
      write(0, 8'h9F);
      write(2, 8'h10);
`ifdef SQGEN_LENGTH_EN
      write(3, 8'h18);
      tick();
      check("t6_lc_load", 16'(bus_a.SQ_LC), 16'd1);
      half_tick();
      tick();
      check("t6_lc_len1", 16'(bus_a.SQ_LC), 16'd1);
      half_tick();
      tick();
      check("t6_lc_len0", 16'(bus_a.SQ_LC), 16'd0);
      tick();
      check("t6_out_len0", 16'(bus_a.SQ_Out), 16'd0);
      db = 8'h18; wr3 = 1'b1; nlfo2 = 1'b0;
      tick();
      wr3 = 1'b0; nlfo2 = 1'b1;
      half_tick();
      tick();
      check("t6_load_wins", 16'(bus_a.SQ_LC), 16'd1);
      write(3, 8'h18);
      tick();
      check("t6_lc_reload", 16'(bus_a.SQ_LC), 16'd1);
      nosq = 1'b1;
      tick();
      nosq = 1'b0;
      tick();
      check("t6_nosq_clr", 16'(bus_a.SQ_LC), 16'd0);
      tick();
      check("t6_nosq_stay", 16'(bus_a.SQ_LC), 16'd0);
`else
      nosq = 1'b1;
      tick();
      check("t6_nosq_lc", 16'(bus_a.SQ_LC), 16'd0);
      nosq = 1'b0;
      tick();
      check("t6_nosq_rel", 16'(bus_a.SQ_LC), 16'd1);
`endif

      // LOCK gating, then asynchronous reset mid-operation
      write(0, 8'hDF);
      write(3, 8'h00);
      write(3, 8'h00);
      tick();
      check("t6_run_a", 16'(bus_a.SQ_Out), 16'd15);
      check("t6_run_b", 16'(bus_b.SQ_Out), 16'd15);
      lock = 1'b1;
      write(3, 8'h00);
      tick();
      check("t6_lock", 16'(bus_a.SQ_Out), 16'd0);
      lock = 1'b0;
      write(3, 8'h00);
      tick();
      check("t6_unlock", 16'(bus_a.SQ_Out), 16'd15);
      #2;
      n_res = 1'b0;
      #1;
      check("t6_arst_out_a", 16'(bus_a.SQ_Out), 16'd0);
      check("t6_arst_out_b", 16'(bus_b.SQ_Out), 16'd0);
      check("t6_arst_lc", 16'(bus_a.SQ_LC), 16'd0);
      check("t6_arst_per", 16'(u_a.per_q), 16'h0);
      tick();
      n_res = 1'b1;
      tick();
      check("t6_post_per", 16'(u_a.per_q), 16'h0);
      check("t6_post_out", 16'(bus_a.SQ_Out), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
